// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle ops and an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to build the MUL opcode; otherwise opcode 1001 is reported as illegal.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    assign shamt = data2_in[SHW-1:0];
    assign sum   = data1_in + data2_in;
    assign diff  = data1_in - data2_in;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUCtrl)
            OP_AND:  alu_res = data1_in & data2_in;
            OP_OR:   alu_res = data1_in | data2_in;
            OP_XOR:  alu_res = data1_in ^ data2_in;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (data1_in[WIDTH-1] == data2_in[WIDTH-1]) &&
                          (sum[WIDTH-1] != data1_in[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (data1_in[WIDTH-1] != data2_in[WIDTH-1]) &&
                          (diff[WIDTH-1] != data1_in[WIDTH-1]);
            end
            OP_SLL:  alu_res = data1_in << shamt;
            OP_SRL:  alu_res = data1_in >> shamt;
            OP_SRA:  alu_res = $signed(data1_in) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_in) < $signed(data2_in)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data1_in < data2_in};
`ifdef ALU_MUL_EN
            // Handled by the multiplier FSM; this entry only keeps it out of the illegal set.
            4'b1001: alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0]     OP_MUL = 4'b1001;
    localparam logic [SHW-1:0] LAST   = SHW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    // One multiplier bit per cycle; the multiplicand walks left so the sum wraps naturally.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        done_d = 1'b0;
        data_d = data_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        ill_d  = ill_q;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ALUCtrl == OP_MUL) begin
                        state_d  = S_MUL;
                        busy_d   = 1'b1;
                        acc_d    = '0;
                        mcand_d  = data1_in;
                        mplier_d = data2_in;
                        cnt_d    = '0;
                    end else begin
                        done_d = 1'b1;
                        data_d = alu_res;
                        zero_d = (alu_res == '0);
                        ovf_d  = alu_ovf;
                        ill_d  = alu_ill;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    data_d  = acc_step;
                    zero_d  = (acc_step == '0);
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (start) begin
            done_d = 1'b1;
            data_d = alu_res;
            zero_d = (alu_res == '0);
            ovf_d  = alu_ovf;
            ill_d  = alu_ill;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MUL_EN
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q   <= done_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
`ifdef ALU_MUL_EN
            state_q  <= state_d;
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

`ifdef ALU_MUL_EN
    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif
    assign done     = done_q;
    assign data     = data_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign Illegal  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table plus hand-written MUL/reset sequences.
// Expected results are queued when an operation is issued and compared when done rises.
module tb_alu_multicycle;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] data1_in;
    logic [WIDTH-1:0] data2_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data;
    logic             Zero;
    logic             Overflow;
    logic             Illegal;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        exp;
        int          lat;
        int          bcnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ALUCtrl  (ALUCtrl),
        .data1_in (data1_in),
        .data2_in (data2_in),
        .busy     (busy),
        .done     (done),
        .data     (data),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Illegal  (Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic exp_t mk_exp(logic [31:0] d, logic o, logic i);
        exp_t e;
        e.data = d;
        e.zero = (d == 32'h0);
        e.ovf  = o;
        e.ill  = i;
        return e;
    endfunction

    function automatic void add_vec(string n, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                    logic [31:0] d, logic o, logic i, int lat, int bc);
        vec_t v;
        v.name = n;
        v.op   = op;
        v.a    = a;
        v.b    = b;
        v.exp  = mk_exp(d, o, i);
        v.lat  = lat;
        v.bcnt = bc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one start pulse and returns #1 after the edge that samples it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input exp_t e);
        @(negedge clk);
        start    = 1'b1;
        ALUCtrl  = op;
        data1_in = a;
        data2_in = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles; optionally pulses start at cycle inject_at.
    task automatic checkOutput(input string name, input int exp_lat, input int exp_busy,
                               input int inject_at);
        int   n  = 0;
        int   bc = 0;
        exp_t e;
        if (busy === 1'b1) bc++;
        while (done !== 1'b1 && n < WIDTH + 8) begin
            if (n == inject_at) begin
                start    = 1'b1;
                ALUCtrl  = 4'b0010;
                data1_in = 32'h1;
                data2_in = 32'h1;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) bc++;
        end
        start = 1'b0;
        check({name, " done"}, {63'h0, done}, 64'h1);
        check({name, " latency"}, 64'(n), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(bc), 64'(exp_busy));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb.pop_front();
            check({name, " data"}, 64'(data), 64'(e.data));
            check({name, " Zero"}, {63'h0, Zero}, {63'h0, e.zero});
            check({name, " Overflow"}, {63'h0, Overflow}, {63'h0, e.ovf});
            check({name, " Illegal"}, {63'h0, Illegal}, {63'h0, e.ill});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, {63'h0, busy}, 64'h0);
        check({tag, " done"}, {63'h0, done}, 64'h0);
        check({tag, " data"}, 64'(data), 64'h0);
        check({tag, " Zero"}, {63'h0, Zero}, 64'h1);
        check({tag, " Overflow"}, {63'h0, Overflow}, 64'h0);
        check({tag, " Illegal"}, {63'h0, Illegal}, 64'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ALUCtrl  = 4'h0;
        data1_in = '0;
        data2_in = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        add_vec("and",      4'b0000, 32'hF0F0F0F0, 32'h0FF0FF00, 32'h00F0F000, 1'b0, 1'b0, 0, 0);
        add_vec("or",       4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 0, 0);
        add_vec("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 0, 0);
        add_vec("ill_1111", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 0, 0);
        add_vec("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 0, 0);
`ifdef ALU_MUL_EN
        add_vec("mul_wrap", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32, 32);
`else
        add_vec("ill_1001", 4'b1001, 32'h00010001, 32'h00010001, 32'h00000000, 1'b0, 1'b1, 0, 0);
`endif
        add_vec("xor_zero", 4'b0011, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0, 0, 0);
        add_vec("sll_31",   4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 0, 0);
`ifdef ALU_MUL_EN
        add_vec("mul_zero", 4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 32, 32);
`endif
        add_vec("srl_4",    4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 0, 0);
        add_vec("sub_eq",   4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 0, 0);
        add_vec("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 0);
        add_vec("sra_4",    4'b1000, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 0, 0);
        add_vec("sltu",     4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0, 0);
        add_vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0, 0);
        add_vec("slt_pos",  4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 0, 0);
        add_vec("ill_1011", 4'b1011, 32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 1'b1, 0, 0);
        add_vec("add_2_3",  4'b0010, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 0, 0);

        // Each op is issued in the done cycle of the previous one, so this is also back-to-back.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            checkOutput(vecs[i].name, vecs[i].lat, vecs[i].bcnt, -1);
        end

        @(posedge clk);
        #1;
        check("hold done", {63'h0, done}, 64'h0);
        check("hold data", 64'(data), 64'h5);

`ifdef ALU_MUL_EN
        applyStimulus(4'b1001, 32'h00010001, 32'h00010001, mk_exp(32'h00020001, 1'b0, 1'b0));
        checkOutput("mul_10001", 32, 32, 5);
        @(posedge clk);
        #1;
        check("mul_after done", {63'h0, done}, 64'h0);
        check("mul_after data", 64'(data), 64'h00020001);

        applyStimulus(4'b1001, 32'h12345678, 32'h9ABCDEF1, mk_exp(32'h0, 1'b0, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        check("mul_mid busy", {63'h0, busy}, 64'h1);
        check("mul_mid data", 64'(data), 64'h00020001);
`else
        applyStimulus(4'b0001, 32'h0000F000, 32'h00000F00, mk_exp(32'h0000FF00, 1'b0, 1'b0));
        checkOutput("or_pre_rst", 0, 0, -1);
`endif
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        @(posedge clk);
        #1;
        check("abort no_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        applyStimulus(4'b0010, 32'h00000002, 32'h00000003, mk_exp(32'h5, 1'b0, 1'b0));
        checkOutput("add_after_rst", 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/result width in bits; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port ALUCtrl, input, 4, the opcode.
REQ-006 The block SHALL have ports data1_in and data2_in, inputs, WIDTH each, operands A and B.
REQ-007 The block SHALL have port busy, output, 1, high while a multi-cycle operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port data, output, WIDTH, the registered result.
REQ-010 The block SHALL have ports Zero, Overflow and Illegal, outputs, 1 each: result==0, signed add/sub overflow, and unsupported opcode.

Function
REQ-011 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 MUL (low WIDTH bits of A*B), 1010 SLTU; all other codes are illegal.
REQ-012 The block SHALL accept start only while busy=0, latching ALUCtrl and both operands at the accepting edge; start while busy=1 is ignored.
REQ-013 For every non-MUL opcode, the result SHALL be registered at the accepting edge, with done=1 for exactly the following cycle and busy staying 0.
REQ-014 MUL SHALL be an iterative shift-add with one operand bit per cycle: busy=1 from the accepting edge through WIDTH further edges, then busy=0 and done=1 in the same cycle.
REQ-015 The FSM SHALL have the states IDLE to MUL on an accepted MUL, MUL to IDLE after WIDTH iterations, and IDLE to IDLE for all other accepted ops.
REQ-016 The shift amount SHALL be data2_in[log2(WIDTH)-1:0]; upper bits are ignored; SRA replicates A's MSB.
REQ-017 SLT and SLTU SHALL output 1 or 0 zero-extended to WIDTH.
REQ-018 Zero SHALL equal (data==0) for every opcode, including SLT, SLTU and illegal.
REQ-019 Overflow SHALL be set only for ADD or SUB with signed overflow; it is 0 otherwise.
REQ-020 An illegal opcode SHALL produce data=0, Zero=1, Illegal=1, with single-cycle timing as in REQ-013.
REQ-021 data, Zero, Overflow and Illegal SHALL hold their values until the next completed operation; during MUL they keep the previous result.
REQ-022 Back-to-back SHALL be supported: start in the cycle done=1 (busy=0) is accepted.
REQ-023 MUL SHALL wrap modulo 2^WIDTH, and Overflow stays 0 for MUL.

Reset
REQ-024 While rst_n=0, the block SHALL hold FSM=IDLE, busy=0, done=0, data=0, Zero=1, Overflow=0, Illegal=0, and the iteration counter at 0.
REQ-025 rst_n asserted mid-MUL SHALL abort the operation immediately, with no done pulse; after release the block accepts start on the first edge.

Configuration
REQ-026 With macro ALU_MUL_EN defined, MUL SHALL be implemented per REQ-014.
REQ-027 With ALU_MUL_EN undefined, opcode 1001 SHALL be treated as illegal per REQ-020, the MUL state and datapath are absent, and busy is tied to 0.

Verification
REQ-028 The bench SHALL cover: WIDTH=32, ADD A=0x7FFFFFFF B=1 -> next cycle done=1, data=0x80000000, Overflow=1, Zero=0.
REQ-029 The bench SHALL cover: SUB A=5 B=5 -> data=0, Zero=1; SLT A=0xFFFFFFFF B=1 -> data=1; SLTU same operands -> data=0, Zero=1.
REQ-030 The bench SHALL cover: SRA A=0x80000000 B=0x24 (shift 4) -> data=0xF8000000; SLL A=1 B=31 -> data=0x80000000.
REQ-031 The bench SHALL cover: with ALU_MUL_EN, MUL A=0x10001 B=0x10001 -> busy high 32 cycles, then done=1, data=0x00020001; a start pulsed mid-operation is ignored.
REQ-032 The bench SHALL cover: rst_n low at iteration 10 of MUL -> busy=0, data=0, Zero=1, no done; a following ADD 2+3 gives data=5 one cycle after start.
REQ-033 The bench SHALL cover: without ALU_MUL_EN, opcode 1001, and separately opcode 1111 -> one cycle later done=1, Illegal=1, data=0, Zero=1, busy never high.
